fd_pipe_reg: RTL and testbench
==============================

// Module: fd_pipe_reg
// PURPOSE
//  Fetch->decode pipeline register built as a 2-entry skid buffer (main slot + skid slot).
//  - Captures instr/pc/pre_pc/commit_info from fetch; presents them to decode one cycle later.
//  - Decouples fetch from decode back-pressure without a combinational ready path to fetch.
//  - Drops all buffered entries on a redirect flush.
// PARAMETERS
//  XLEN      64   PC width
//  INSTR_W   32   instruction width
//  COMMIT_W  161  commit bundle width = 1+INSTR_W+2*XLEN, layout {commit,instr,pre_pc,pc}
//  CNT_W     32   perf counter width (used only with FD_PERF_CNT_EN)
// PORTS
//  clk                  in   1         clock, rising edge
//  rst                  in   1         synchronous reset, active-high
//  fd_i_valid           in   1         fetch presents a valid instruction
//  fd_o_ready           out  1         buffer accepts from fetch (registered)
//  fd_i_instr           in   INSTR_W   instruction from fetch
//  fd_i_pc              in   XLEN      PC of instruction
//  fd_i_pre_pc          in   XLEN      predicted next PC
//  fd_i_commit_info     in   COMMIT_W  commit bundle from fetch
//  fd_i_flush           in   1         redirect: discard all buffered entries
//  fd_o_valid           out  1         entry presented to decode
//  fd_i_ready           in   1         decode accepts this cycle
//  fd_o_instr           out  INSTR_W   head instruction
//  fd_o_pc              out  XLEN      head PC
//  fd_o_pre_pc          out  XLEN      head predicted PC
//  fd_o_commit_info     out  COMMIT_W  head commit bundle; bit[COMMIT_W-1] forced 0 when !fd_o_valid
//  fd_o_stall_cnt       out  CNT_W     cycles with fd_o_valid && !fd_i_ready
//  fd_o_flush_cnt       out  CNT_W     flushes that discarded >=1 valid entry
// BEHAVIOUR
//  - Reset: both slots invalid, all data regs 0, fd_o_valid=0, fd_o_ready=1, counters 0.
//  - Push = fd_i_valid && fd_o_ready; pop = fd_o_valid && fd_i_ready.
//  - Latency: push in cycle N visible on fd_o_* in N+1 if main slot empty or popped in N.
//  - fd_o_ready = !skid_valid, straight from a flop; no combinational path from fd_i_ready.
//  - Occupancy states: EMPTY -> ONE (main) -> TWO (main+skid).
//    - EMPTY: push -> ONE.
//    - ONE: push&pop -> ONE with main<=input; push&!pop -> TWO with skid<=input; pop&!push -> EMPTY.
//    - TWO: pop -> ONE with main<=skid; push impossible because fd_o_ready=0.
//  - Order strictly FIFO; skid never overtakes main.
//  - fd_i_valid while fd_o_ready=0 is ignored; fetch holds its data.
//  - Flush wins over everything in the same cycle: both slots invalid, push and pop discarded,
//    state EMPTY, fd_o_ready=1 next cycle.
//  - rst overrides flush; reset mid-operation discards entries exactly like flush and clears counters.
//  - Output data muxing from slot regs only; fd_o_* hold stable while fd_o_valid && !fd_i_ready.
// CONFIGURATION
//  FD_PERF_CNT_EN defined:
//    - stall/flush counters are live.
//    - Counters are saturating at 2^CNT_W-1, never wrap.
//  FD_PERF_CNT_EN undefined:
//    - Ports remain present and are tied to 0; no counter flops are built.
// STRUCTURE
//  - fd_pkg:
//    - localparams XLEN, INSTR_W, COMMIT_W.
//    - typedef struct packed fd_entry_t {instr, pc, pre_pc, commit_info}.
//    - enum fd_occ_e {FD_EMPTY, FD_ONE, FD_TWO}.
//  - Sub-module fd_slot: one fd_entry_t + valid flop with load/clear; instantiated twice (main, skid).
//  - Top holds occupancy control, output mux and counters.
// TESTING
//  - Reset: rst=1 for 2 cycles -> fd_o_valid=0, fd_o_ready=1, fd_o_commit_info=0, counters 0.
//  - Stream, decode always ready: pc=0x80000000,+4,+8 pushed on cycles 1-3 -> same pcs out on
//    cycles 2-4, fd_o_ready stays 1.
//  - Backpressure: fd_i_ready=0, push 0x80000000 then 0x80000004 -> fd_o_ready=0 after 2nd push;
//    release -> 0x80000000 then 0x80000004 out in order, fd_o_ready back to 1.
//  - Flush in TWO with simultaneous fd_i_valid (pc=0x80000010) -> next cycle fd_o_valid=0,
//    0x80000010 not delivered, flush_cnt=1 (with FD_PERF_CNT_EN).
//  - Push&pop in ONE: main=0x80000000, fd_i_ready=1, push 0x80000004 -> next cycle head=0x80000004,
//    still ONE, fd_o_ready=1.
//  - Counters: 5 cycles valid && !ready -> stall_cnt=5; CNT_W=3, 10 stall cycles -> stall_cnt=7;
//    without macro both counters read 0.

Source files
------------

// File: rtl/fd_pkg.sv
// Shared types for the fetch->decode pipeline register: entry layout and occupancy encoding.
package fd_pkg;

  localparam int XLEN     = 64;
  localparam int INSTR_W  = 32;
  localparam int COMMIT_W = 1 + INSTR_W + 2 * XLEN;

  typedef struct packed {
    logic [INSTR_W-1:0]  instr;
    logic [XLEN-1:0]     pc;
    logic [XLEN-1:0]     pre_pc;
    logic [COMMIT_W-1:0] commit_info;
  } fd_entry_t;

  typedef enum logic [1:0] {
    FD_EMPTY = 2'd0,
    FD_ONE   = 2'd1,
    FD_TWO   = 2'd2
  } fd_occ_e;

endpackage

// File: rtl/fd_slot.sv
// One buffered fetch entry plus its valid bit; clear takes priority over load.
// Latency: load visible one cycle later. Backpressure: none, controlled entirely by the parent.
module fd_slot
  import fd_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      load,
  input  logic      clear,
  input  fd_entry_t d,
  output logic      valid,
  output fd_entry_t q
);

  logic      valid_q, valid_d;
  fd_entry_t entry_q, entry_d;

  always_comb begin
    valid_d = valid_q;
    entry_d = entry_q;
    if (clear) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d = 1'b1;
      entry_d = d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      entry_q <= '0;
    end else begin
      valid_q <= valid_d;
      entry_q <= entry_d;
    end
  end

  assign valid = valid_q;
  assign q     = entry_q;

endmodule

// File: rtl/fd_pipe_reg.sv
// Fetch->decode register as a 2-entry skid buffer; 1-cycle latency; fd_o_ready is a flop (no path from fd_i_ready).
// Flush drops both slots. FD_PERF_CNT_EN enables saturating stall/flush counters, else they read 0.
module fd_pipe_reg
  import fd_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                fd_i_valid,
  output logic                fd_o_ready,
  input  logic [INSTR_W-1:0]  fd_i_instr,
  input  logic [XLEN-1:0]     fd_i_pc,
  input  logic [XLEN-1:0]     fd_i_pre_pc,
  input  logic [COMMIT_W-1:0] fd_i_commit_info,
  input  logic                fd_i_flush,
  output logic                fd_o_valid,
  input  logic                fd_i_ready,
  output logic [INSTR_W-1:0]  fd_o_instr,
  output logic [XLEN-1:0]     fd_o_pc,
  output logic [XLEN-1:0]     fd_o_pre_pc,
  output logic [COMMIT_W-1:0] fd_o_commit_info,
  output logic [CNT_W-1:0]    fd_o_stall_cnt,
  output logic [CNT_W-1:0]    fd_o_flush_cnt
);

  fd_occ_e   occ_q, occ_d;
  fd_entry_t in_entry, main_din, main_q, skid_q;
  logic      main_vld, skid_vld;
  logic      main_load, main_clr, main_from_skid, skid_load, skid_clr;
  logic      push, pop;

  assign in_entry = '{instr: fd_i_instr, pc: fd_i_pc, pre_pc: fd_i_pre_pc,
                      commit_info: fd_i_commit_info};

  assign push = fd_i_valid && fd_o_ready;
  assign pop  = fd_o_valid && fd_i_ready;

  always_comb begin
    occ_d          = occ_q;
    main_load      = 1'b0;
    main_clr       = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    skid_clr       = 1'b0;
    case (occ_q)
      FD_EMPTY: begin
        if (push) begin
          main_load = 1'b1;
          occ_d     = FD_ONE;
        end
      end
      FD_ONE: begin
        if (push && pop) begin
          main_load = 1'b1;
        end else if (push) begin
          skid_load = 1'b1;
          occ_d     = FD_TWO;
        end else if (pop) begin
          main_clr = 1'b1;
          occ_d    = FD_EMPTY;
        end
      end
      FD_TWO: begin
        if (pop) begin
          main_load      = 1'b1;
          main_from_skid = 1'b1;
          skid_clr       = 1'b1;
          occ_d          = FD_ONE;
        end
      end
      default: begin
        main_clr = 1'b1;
        skid_clr = 1'b1;
        occ_d    = FD_EMPTY;
      end
    endcase
    // Flush overrides any push/pop decided above.
    if (fd_i_flush) begin
      occ_d     = FD_EMPTY;
      main_load = 1'b0;
      skid_load = 1'b0;
      main_clr  = 1'b1;
      skid_clr  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) occ_q <= FD_EMPTY;
    else     occ_q <= occ_d;
  end

  assign main_din = main_from_skid ? skid_q : in_entry;

  fd_slot u_main (
    .clk   (clk),
    .rst   (rst),
    .load  (main_load),
    .clear (main_clr),
    .d     (main_din),
    .valid (main_vld),
    .q     (main_q)
  );

  fd_slot u_skid (
    .clk   (clk),
    .rst   (rst),
    .load  (skid_load),
    .clear (skid_clr),
    .d     (in_entry),
    .valid (skid_vld),
    .q     (skid_q)
  );

  assign fd_o_ready       = !skid_vld;
  assign fd_o_valid       = main_vld;
  assign fd_o_instr       = main_q.instr;
  assign fd_o_pc          = main_q.pc;
  assign fd_o_pre_pc      = main_q.pre_pc;
  // Slot data survives a flush, so the commit flag must be masked by valid.
  assign fd_o_commit_info = {main_vld & main_q.commit_info[COMMIT_W-1],
                             main_q.commit_info[COMMIT_W-2:0]};

`ifdef FD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (fd_o_valid && !fd_i_ready && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (fd_i_flush && (occ_q != FD_EMPTY) && (flush_cnt_q != '1))
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign fd_o_stall_cnt = stall_cnt_q;
  assign fd_o_flush_cnt = flush_cnt_q;
`else
  assign fd_o_stall_cnt = '0;
  assign fd_o_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_fd_pipe_reg.sv
// Directed bench for fd_pipe_reg: vector table plus reset, counter-saturation and mid-run reset sequences.
module tb_fd_pipe_reg;
  import fd_pkg::*;

  logic                clk = 1'b0;
  logic                rst;
  logic                fd_i_valid, fd_i_ready, fd_i_flush;
  logic [INSTR_W-1:0]  fd_i_instr;
  logic [XLEN-1:0]     fd_i_pc, fd_i_pre_pc;
  logic [COMMIT_W-1:0] fd_i_commit_info;

  logic                fd_o_ready, fd_o_valid;
  logic [INSTR_W-1:0]  fd_o_instr;
  logic [XLEN-1:0]     fd_o_pc, fd_o_pre_pc;
  logic [COMMIT_W-1:0] fd_o_commit_info;
  logic [31:0]         fd_o_stall_cnt, fd_o_flush_cnt;

  logic                s_ready, s_valid;
  logic [INSTR_W-1:0]  s_instr;
  logic [XLEN-1:0]     s_pc, s_pre_pc;
  logic [COMMIT_W-1:0] s_commit;
  logic [2:0]          s_stall_cnt, s_flush_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  fd_pipe_reg #(.CNT_W(32)) dut (
    .clk(clk), .rst(rst), .fd_i_valid(fd_i_valid), .fd_o_ready(fd_o_ready),
    .fd_i_instr(fd_i_instr), .fd_i_pc(fd_i_pc), .fd_i_pre_pc(fd_i_pre_pc),
    .fd_i_commit_info(fd_i_commit_info), .fd_i_flush(fd_i_flush),
    .fd_o_valid(fd_o_valid), .fd_i_ready(fd_i_ready), .fd_o_instr(fd_o_instr),
    .fd_o_pc(fd_o_pc), .fd_o_pre_pc(fd_o_pre_pc), .fd_o_commit_info(fd_o_commit_info),
    .fd_o_stall_cnt(fd_o_stall_cnt), .fd_o_flush_cnt(fd_o_flush_cnt)
  );

  fd_pipe_reg #(.CNT_W(3)) dut_small (
    .clk(clk), .rst(rst), .fd_i_valid(fd_i_valid), .fd_o_ready(s_ready),
    .fd_i_instr(fd_i_instr), .fd_i_pc(fd_i_pc), .fd_i_pre_pc(fd_i_pre_pc),
    .fd_i_commit_info(fd_i_commit_info), .fd_i_flush(fd_i_flush),
    .fd_o_valid(s_valid), .fd_i_ready(fd_i_ready), .fd_o_instr(s_instr),
    .fd_o_pc(s_pc), .fd_o_pre_pc(s_pre_pc), .fd_o_commit_info(s_commit),
    .fd_o_stall_cnt(s_stall_cnt), .fd_o_flush_cnt(s_flush_cnt)
  );

  typedef struct {
    logic        v;
    logic        rdy;
    logic        fl;
    logic [63:0] pc;
    logic        ev;
    logic        erdy;
    logic [63:0] epc;
    int          escnt;
    int          efcnt;
  } vec_t;

  vec_t vecs[17];

  function automatic logic [INSTR_W-1:0] instr_of(input logic [63:0] pc);
    return pc[31:0] ^ 32'h1357_9bdf;
  endfunction

  function automatic logic [COMMIT_W-1:0] commit_of(input logic [63:0] pc);
    return {1'b1, instr_of(pc), pc + 64'd4, pc};
  endfunction

  function automatic int cnt_exp(input int v);
`ifdef FD_PERF_CNT_EN
    return v;
`else
    return 0;
`endif
  endfunction

  task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic rdy, input logic fl, input logic [63:0] pc);
    fd_i_valid       = v;
    fd_i_ready       = rdy;
    fd_i_flush       = fl;
    fd_i_pc          = pc;
    fd_i_pre_pc      = pc + 64'd4;
    fd_i_instr       = instr_of(pc);
    fd_i_commit_info = commit_of(pc);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //           v     rdy   fl    pc              ev    erdy  epc             stall flush
    vecs[0]  = '{1'b1, 1'b1, 1'b0, 64'h8000_0000, 1'b1, 1'b1, 64'h8000_0000, 0, 0};
    vecs[1]  = '{1'b1, 1'b1, 1'b0, 64'h8000_0004, 1'b1, 1'b1, 64'h8000_0004, 0, 0};
    vecs[2]  = '{1'b1, 1'b1, 1'b0, 64'h8000_0008, 1'b1, 1'b1, 64'h8000_0008, 0, 0};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 64'h0,         1'b0, 1'b1, 64'h0,         0, 0};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 64'h8000_0000, 1'b1, 1'b1, 64'h8000_0000, 0, 0};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 64'h8000_0004, 1'b1, 1'b0, 64'h8000_0000, 1, 0};
    vecs[6]  = '{1'b1, 1'b0, 1'b0, 64'h8000_0008, 1'b1, 1'b0, 64'h8000_0000, 2, 0};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 64'h0,         1'b1, 1'b1, 64'h8000_0004, 2, 0};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 64'h0,         1'b0, 1'b1, 64'h0,         2, 0};
    vecs[9]  = '{1'b1, 1'b0, 1'b0, 64'h8000_0000, 1'b1, 1'b1, 64'h8000_0000, 2, 0};
    vecs[10] = '{1'b1, 1'b1, 1'b0, 64'h8000_0004, 1'b1, 1'b1, 64'h8000_0004, 2, 0};
    vecs[11] = '{1'b1, 1'b0, 1'b0, 64'h8000_0008, 1'b1, 1'b0, 64'h8000_0004, 3, 0};
    vecs[12] = '{1'b1, 1'b1, 1'b1, 64'h8000_0010, 1'b0, 1'b1, 64'h0,         3, 1};
    vecs[13] = '{1'b0, 1'b1, 1'b0, 64'h0,         1'b0, 1'b1, 64'h0,         3, 1};
    vecs[14] = '{1'b0, 1'b1, 1'b1, 64'h0,         1'b0, 1'b1, 64'h0,         3, 1};
    vecs[15] = '{1'b1, 1'b0, 1'b0, 64'h8000_0020, 1'b1, 1'b1, 64'h8000_0020, 3, 1};
    vecs[16] = '{1'b0, 1'b0, 1'b1, 64'h0,         1'b0, 1'b1, 64'h0,         4, 2};

    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 64'h0);
    tick();
    tick();
    check("rst_valid",  192'(fd_o_valid), 192'(0));
    check("rst_ready",  192'(fd_o_ready), 192'(1));
    check("rst_commit", 192'(fd_o_commit_info), 192'(0));
    check("rst_stall",  192'(fd_o_stall_cnt), 192'(0));
    check("rst_flush",  192'(fd_o_flush_cnt), 192'(0));
    rst = 1'b0;

    for (int i = 0; i < 17; i++) begin
      drive(vecs[i].v, vecs[i].rdy, vecs[i].fl, vecs[i].pc);
      tick();
      check($sformatf("r%0d_valid", i), 192'(fd_o_valid), 192'(vecs[i].ev));
      check($sformatf("r%0d_ready", i), 192'(fd_o_ready), 192'(vecs[i].erdy));
      if (vecs[i].ev) begin
        check($sformatf("r%0d_pc", i),     192'(fd_o_pc),     192'(vecs[i].epc));
        check($sformatf("r%0d_instr", i),  192'(fd_o_instr),  192'(instr_of(vecs[i].epc)));
        check($sformatf("r%0d_prepc", i),  192'(fd_o_pre_pc), 192'(vecs[i].epc + 64'd4));
        check($sformatf("r%0d_commit", i), 192'(fd_o_commit_info), 192'(commit_of(vecs[i].epc)));
      end else begin
        check($sformatf("r%0d_cflag", i), 192'(fd_o_commit_info[COMMIT_W-1]), 192'(0));
      end
      check($sformatf("r%0d_stall", i), 192'(fd_o_stall_cnt), 192'(cnt_exp(vecs[i].escnt)));
      check($sformatf("r%0d_flush", i), 192'(fd_o_flush_cnt), 192'(cnt_exp(vecs[i].efcnt)));
    end

    // Stall counting and 3-bit saturation
    rst = 1'b1;
    drive(1'b0, 1'b1, 1'b0, 64'h0);
    tick();
    rst = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 64'h8000_0100);
    tick();
    drive(1'b0, 1'b0, 1'b0, 64'h0);
    repeat (5) tick();
    check("stall5_big",   192'(fd_o_stall_cnt), 192'(cnt_exp(5)));
    check("stall5_small", 192'(s_stall_cnt),    192'(cnt_exp(5)));
    repeat (5) tick();
    check("stall10_big",   192'(fd_o_stall_cnt), 192'(cnt_exp(10)));
    check("stall10_small", 192'(s_stall_cnt),    192'(cnt_exp(7)));
    check("stall10_flush", 192'(fd_o_flush_cnt), 192'(0));
    check("hold_pc",       192'(fd_o_pc),        192'(64'h8000_0100));

    // Mid-run reset while full discards entries and counters
    drive(1'b1, 1'b0, 1'b0, 64'h8000_0104);
    tick();
    check("full_ready", 192'(fd_o_ready), 192'(0));
    rst = 1'b1;
    drive(1'b1, 1'b0, 1'b1, 64'h8000_0108);
    tick();
    rst = 1'b0;
    drive(1'b0, 1'b1, 1'b0, 64'h0);
    check("mrst_valid", 192'(fd_o_valid),     192'(0));
    check("mrst_ready", 192'(fd_o_ready),     192'(1));
    check("mrst_stall", 192'(fd_o_stall_cnt), 192'(0));
    check("mrst_flush", 192'(fd_o_flush_cnt), 192'(0));
    tick();
    check("mrst_after", 192'(fd_o_valid), 192'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
